// File: rtl/riscv_fetch.sv
// riscv_fetch: instruction prefetcher with credit-limited req/gnt/rvalid fetch, prefetch FIFO and redirect flush
module riscv_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [29:0] instr_pc,
  input  logic        instr_ready,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t          r_state, w_state_nxt;
  logic [29:0]     r_fetch_pc, r_resp_pc;
  logic [CW-1:0]   r_outstanding, r_drain, r_count, w_drain_nxt;
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [31:0]     r_data [DEPTH];
  logic [29:0]     r_pc   [DEPTH];
  logic [CW:0]     w_credit;
  logic            w_run, w_grant, w_push, w_pop;
  assign w_run       = r_state == RUN;
  assign w_credit    = {1'b0, r_count} + {1'b0, r_outstanding};
  assign mem_req     = w_run && !redirect_valid && (w_credit < (CW+1)'(DEPTH));
  assign mem_addr    = r_fetch_pc;
  assign w_grant     = mem_req && mem_gnt;
  assign w_push      = w_run && mem_rvalid && !redirect_valid;
  assign instr_valid = r_count != '0;
  assign w_pop       = instr_valid && instr_ready;
  assign instr       = instr_valid ? r_data[r_rptr] : '0;
  assign instr_pc    = instr_valid ? r_pc[r_rptr] : '0;
  // responses still in flight at a redirect become the drain count; in FLUSH each rvalid retires one
  assign w_drain_nxt = (r_state == FLUSH) ? r_drain - CW'(mem_rvalid && r_drain != '0) :
                       (w_run && redirect_valid) ? r_outstanding + CW'(w_grant) - CW'(mem_rvalid) : '0;
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE) w_state_nxt = RUN;
    else if (r_state == FLUSH || redirect_valid) w_state_nxt = (w_drain_nxt == '0) ? RUN : FLUSH;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drain       <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
      if (redirect_valid) begin
        r_fetch_pc    <= redirect_pc;
        r_resp_pc     <= redirect_pc;
        r_outstanding <= '0;
        r_count       <= '0;
        r_wptr        <= '0;
        r_rptr        <= '0;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + 30'd1;
        if (w_push) r_resp_pc <= r_resp_pc + 30'd1;
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop) r_rptr <= r_rptr + 1'b1;
        r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_push);
        r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wptr] <= mem_rdata;
      r_pc[r_wptr]   <= r_resp_pc;
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && r_count == CW'(DEPTH)));
endmodule

// File: tb/tb_riscv_fetch.sv
// tb_riscv_fetch: directed vector table plus hand sequences for reset, backpressure and wrap cases
module tb_riscv_fetch;
  logic        clk = 0, rst_n = 0, redirect_valid = 0, instr_ready = 0, mem_gnt = 0, mem_rvalid = 0;
  logic [29:0] redirect_pc = '0;
  logic [31:0] mem_rdata = '0;
  logic        instr_valid, mem_req;
  logic [31:0] instr;
  logic [29:0] instr_pc, mem_addr;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  riscv_fetch #(.DEPTH(4), .RESET_PC(30'h0)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );
  typedef struct {
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        rdy, redir;
    logic [29:0] rpc;
    logic        req;
    logic [29:0] addr;
    logic        iv;
    logic [29:0] ipc;
    logic [31:0] ins;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic gnt, rv, input logic [31:0] rdata, input logic rdy, redir,
                     input logic [29:0] rpc, input logic req, input logic [29:0] addr,
                     input logic iv, input logic [29:0] ipc, input logic [31:0] ins);
    vec_t t;
    t.gnt = gnt; t.rv = rv; t.rdata = rdata; t.rdy = rdy; t.redir = redir; t.rpc = rpc;
    t.req = req; t.addr = addr; t.iv = iv; t.ipc = ipc; t.ins = ins;
    tbl.push_back(t);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " mem_req"}, 32'(mem_req), 0);
    chk({tag, " instr_valid"}, 32'(instr_valid), 0);
    chk({tag, " instr"}, instr, 0);
    chk({tag, " instr_pc"}, 32'(instr_pc), 0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 0);
  endtask
  logic        pend;
  logic [29:0] pend_addr;
  int          grants;
  initial begin
    //  gnt rv rdata        rdy redir rpc            req addr          iv ipc           instr
    add(1, 0, 32'h0,        1, 0, 30'h0,         0, 30'h0,        0, 30'h0,        32'h0);
    add(1, 0, 32'h0,        1, 0, 30'h0,         1, 30'h0,        0, 30'h0,        32'h0);
    add(1, 1, 32'h0,        1, 0, 30'h0,         1, 30'h1,        0, 30'h0,        32'h0);
    add(1, 1, 32'h4,        1, 0, 30'h0,         1, 30'h2,        1, 30'h0,        32'h0);
    add(1, 1, 32'h8,        1, 0, 30'h0,         1, 30'h3,        1, 30'h1,        32'h4);
    add(1, 1, 32'hC,        1, 0, 30'h0,         1, 30'h4,        1, 30'h2,        32'h8);
    add(1, 1, 32'h10,       0, 0, 30'h0,         1, 30'h5,        1, 30'h3,        32'hC);
    add(1, 1, 32'h14,       0, 0, 30'h0,         1, 30'h6,        1, 30'h3,        32'hC);
    add(1, 1, 32'h18,       0, 0, 30'h0,         0, 30'h7,        1, 30'h3,        32'hC);
    add(1, 0, 32'h0,        0, 0, 30'h0,         0, 30'h7,        1, 30'h3,        32'hC);
    add(1, 0, 32'h0,        1, 0, 30'h0,         0, 30'h7,        1, 30'h3,        32'hC);
    add(1, 0, 32'h0,        1, 0, 30'h0,         1, 30'h7,        1, 30'h4,        32'h10);
    add(1, 1, 32'h1C,       1, 0, 30'h0,         1, 30'h8,        1, 30'h5,        32'h14);
    add(1, 0, 32'h0,        1, 0, 30'h0,         1, 30'h9,        1, 30'h6,        32'h18);
    add(1, 0, 32'h0,        1, 1, 30'h40,        0, 30'hA,        1, 30'h7,        32'h1C);
    add(1, 1, 32'h20,       1, 0, 30'h0,         0, 30'h40,       0, 30'h0,        32'h0);
    add(1, 1, 32'h24,       1, 0, 30'h0,         0, 30'h40,       0, 30'h0,        32'h0);
    add(1, 0, 32'h0,        1, 0, 30'h0,         1, 30'h40,       0, 30'h0,        32'h0);
    add(1, 1, 32'h100,      1, 0, 30'h0,         1, 30'h41,       0, 30'h0,        32'h0);
    add(1, 1, 32'h104,      1, 0, 30'h0,         1, 30'h42,       1, 30'h40,       32'h100);
    add(1, 0, 32'h0,        0, 0, 30'h0,         1, 30'h43,       1, 30'h41,       32'h104);
    add(1, 1, 32'h108,      1, 1, 30'h80,        0, 30'h44,       1, 30'h41,       32'h104);
    add(1, 1, 32'h10C,      1, 0, 30'h0,         0, 30'h80,       0, 30'h0,        32'h0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 32'h0,      1, 0, 30'h0,         1, 30'h80,       0, 30'h0,        32'h0);
    add(0, 0, 32'h0,        1, 1, 30'h3FFFFFFF,  0, 30'h80,       0, 30'h0,        32'h0);
    add(1, 0, 32'h0,        1, 0, 30'h0,         1, 30'h3FFFFFFF, 0, 30'h0,        32'h0);
    add(1, 1, 32'hFFFFFFFC, 1, 0, 30'h0,         1, 30'h0,        0, 30'h0,        32'h0);
    add(0, 1, 32'h0,        1, 0, 30'h0,         1, 30'h1,        1, 30'h3FFFFFFF, 32'hFFFFFFFC);
    add(0, 0, 32'h0,        1, 0, 30'h0,         1, 30'h1,        1, 30'h0,        32'h0);
    add(1, 0, 32'h0,        1, 0, 30'h0,         1, 30'h1,        0, 30'h0,        32'h0);
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    foreach (tbl[i]) begin
      mem_gnt = tbl[i].gnt; mem_rvalid = tbl[i].rv; mem_rdata = tbl[i].rdata;
      instr_ready = tbl[i].rdy; redirect_valid = tbl[i].redir; redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(tbl[i].req));
      chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
      chk($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(tbl[i].iv));
      chk($sformatf("v%0d instr_pc", i), 32'(instr_pc), 32'(tbl[i].ipc));
      chk($sformatf("v%0d instr", i), instr, tbl[i].ins);
      @(negedge clk);
    end
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h4; instr_ready = 0; redirect_valid = 0;
    #1;
    chk("burst req", 32'(mem_req), 1);
    chk("burst addr", 32'(mem_addr), 2);
    chk("burst valid before write", 32'(instr_valid), 0);
    @(negedge clk);
    mem_rvalid = 0;
    #1;
    chk("burst valid", 32'(instr_valid), 1);
    chk("burst pc", 32'(instr_pc), 1);
    chk("burst instr", instr, 32'h4);
    rst_n = 0;
    #1;
    chk_zero("async reset");
    @(negedge clk);
    rst_n = 1; mem_gnt = 1; instr_ready = 0;
    pend = 0; pend_addr = '0; grants = 0;
    for (int c = 0; c < 10; c++) begin
      mem_rvalid = pend; mem_rdata = {pend_addr, 2'b00};
      #1;
      if (mem_req) grants++;
      pend = mem_req;
      if (mem_req) pend_addr = mem_addr;
      @(negedge clk);
    end
    chk("stall grants", grants, 4);
    mem_rvalid = 0;
    #1;
    chk("stall mem_req", 32'(mem_req), 0);
    chk("stall valid", 32'(instr_valid), 1);
    chk("stall head pc", 32'(instr_pc), 0);
    for (int k = 0; k < 4; k++) begin
      instr_ready = 1; mem_rvalid = pend; mem_rdata = {pend_addr, 2'b00};
      #1;
      chk($sformatf("drain%0d pc", k), 32'(instr_pc), k);
      chk($sformatf("drain%0d instr", k), instr, 32'(k) << 2);
      if (k == 1) begin
        chk("resume req", 32'(mem_req), 1);
        chk("resume addr", 32'(mem_addr), 4);
      end
      pend = mem_req;
      if (mem_req) pend_addr = mem_addr;
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
